// File: rtl/cdf_lut_equalizer.sv
// cdf_lut_equalizer: builds a histogram-CDF remap table into a shadow bank and
// remaps the pixel stream through the active bank, swapping banks at frame boundaries.
module cdf_lut_equalizer #(
  parameter int PIXELS_LOG2 = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hist_valid,
  output logic        hist_rd_en,
  output logic [7:0]  hist_addr,
  input  logic [31:0] hist_data,
  input  logic [7:0]  in_pixel,
  input  logic        in_valid,
  input  logic        end_of_frame,
  output logic [7:0]  out_pixel,
  output logic        out_valid,
  output logic        out_end_of_frame,
  output logic        lut_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d, rd_addr_q, pix_q, out_pixel_q, out_pixel_d;
  logic [31:0] acc_q, acc_d, acc_new;
  logic [39:0] prod, scaled;
  logic [7:0]  lut_wr, lut_rd;
  logic        rd_v_q, pending_q, pending_d, active_q, active_d, ready_q, ready_d;
  logic        eof_prev_q, v1_q, e1_q, out_valid_q, out_eof_q, boundary, swap;
  logic [7:0]  lut_mem [512];
  always_comb begin
    acc_new     = acc_q + hist_data;
    prod        = 40'(acc_new) * 40'd255;
    scaled      = prod >> PIXELS_LOG2;
    lut_wr      = (|scaled[39:8]) ? 8'hff : scaled[7:0];
    boundary    = eof_prev_q & ~end_of_frame;
    swap        = boundary & pending_q & (state_q == IDLE);
    state_d     = state_q;
    addr_d      = addr_q;
    acc_d       = rd_v_q ? acc_new : acc_q;
    pending_d   = swap ? 1'b0 : pending_q;
    active_d    = swap ? ~active_q : active_q;
    ready_d     = swap | ready_q;
    lut_rd      = lut_mem[{active_q, pix_q}];
    out_pixel_d = ready_q ? lut_rd : pix_q;
    if (state_q == IDLE && hist_valid) begin
      state_d = READ;
      addr_d  = 8'd0;
      acc_d   = 32'd0;
    end
    if (state_q == READ) begin
      addr_d  = addr_q + 8'd1;
      state_d = (addr_q == 8'hff) ? DRAIN : READ;
    end
    if (state_q == DRAIN) begin
      state_d   = IDLE;
      pending_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 8'd0;
      rd_addr_q   <= 8'd0;
      acc_q       <= 32'd0;
      rd_v_q      <= 1'b0;
      pending_q   <= 1'b0;
      active_q    <= 1'b0;
      ready_q     <= 1'b0;
      eof_prev_q  <= 1'b0;
      pix_q       <= 8'd0;
      v1_q        <= 1'b0;
      e1_q        <= 1'b0;
      out_pixel_q <= 8'd0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_addr_q   <= addr_q;
      acc_q       <= acc_d;
      rd_v_q      <= hist_rd_en;
      pending_q   <= pending_d;
      active_q    <= active_d;
      ready_q     <= ready_d;
      eof_prev_q  <= end_of_frame;
      pix_q       <= in_pixel;
      v1_q        <= in_valid;
      e1_q        <= end_of_frame;
      out_pixel_q <= out_pixel_d;
      out_valid_q <= v1_q;
      out_eof_q   <= e1_q;
    end
  end
  // Table RAM is deliberately left out of reset; builds only ever target the inactive half.
  always_ff @(posedge clk) begin
    if (rd_v_q) lut_mem[{~active_q, rd_addr_q}] <= lut_wr;
  end
  assign hist_rd_en       = (state_q == READ);
  assign hist_addr        = addr_q;
  assign busy             = (state_q != IDLE);
  assign lut_ready        = ready_q;
  assign out_pixel        = out_pixel_q;
  assign out_valid        = out_valid_q;
  assign out_end_of_frame = out_eof_q;
endmodule

// File: tb/tb_cdf_lut_equalizer.sv
// tb_cdf_lut_equalizer: randomized pixel/histogram stimulus against a CDF-table model
// with a queue scoreboard drained by an independent output monitor.
module tb_cdf_lut_equalizer;
  localparam int PL = 8;
  logic        clk = 0, rst = 1, hist_valid = 0, in_valid = 0, end_of_frame = 0;
  logic        hist_rd_en, out_valid, out_end_of_frame, lut_ready, busy;
  logic [7:0]  hist_addr, in_pixel = 0, out_pixel;
  logic [31:0] hist_data = 0;
  logic [31:0] hist_mem [256];
  logic [7:0]  act_m [256];
  logic [7:0]  shd_m [256];
  logic [8:0]  q [$];
  bit          ready_m, pend_m, bld_on, eof_prev_m;
  int          ncyc, bld_t, checks, failures;

  cdf_lut_equalizer #(.PIXELS_LOG2(PL)) dut (
    .clk(clk), .rst(rst), .hist_valid(hist_valid), .hist_rd_en(hist_rd_en),
    .hist_addr(hist_addr), .hist_data(hist_data), .in_pixel(in_pixel),
    .in_valid(in_valid), .end_of_frame(end_of_frame), .out_pixel(out_pixel),
    .out_valid(out_valid), .out_end_of_frame(out_end_of_frame),
    .lut_ready(lut_ready), .busy(busy));

  always #5 clk = ~clk;

  always @(posedge clk) if (hist_rd_en) hist_data <= hist_mem[hist_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, ncyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h expected=none", {out_end_of_frame, out_pixel});
      end else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("pixel_out", {55'd0, out_end_of_frame, out_pixel}, {55'd0, e});
      end
    end
  end

  // Expected table: normalised running sum of bin counts, 32-bit wrap, saturate at 255.
  task automatic build_model();
    logic [31:0] cum;
    logic [63:0] v;
    cum = 0;
    for (int i = 0; i < 256; i++) begin
      cum += hist_mem[i];
      v = ({32'd0, cum} * 64'd255) >> PL;
      shd_m[i] = (v > 64'd255) ? 8'hff : v[7:0];
    end
  endtask

  task automatic step(input logic hv, input logic [7:0] pix, input logic v, input logic e);
    int  j;
    bit  bsy, rd;
    @(negedge clk);
    ncyc++;
    j   = ncyc - bld_t;
    bsy = bld_on && j >= 1 && j <= 257;
    rd  = bld_on && j >= 1 && j <= 256;
    chk("busy", {63'd0, busy}, {63'd0, bsy});
    chk("hist_rd_en", {63'd0, hist_rd_en}, {63'd0, rd});
    chk("hist_addr", {56'd0, hist_addr}, rd ? 64'(j - 1) : 64'd0);
    chk("lut_ready", {63'd0, lut_ready}, {63'd0, ready_m});
    if (eof_prev_m && !e && pend_m && bld_on && j >= 258) begin
      act_m   = shd_m;
      ready_m = 1;
      pend_m  = 0;
    end
    if (hv && !bsy) begin
      build_model();
      bld_t  = ncyc;
      bld_on = 1;
      pend_m = 1;
    end
    if (v) q.push_back({e, ready_m ? act_m[pix] : pix});
    eof_prev_m   = e;
    hist_valid   = hv;
    in_pixel     = pix;
    in_valid     = v;
    end_of_frame = e;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 8'd0, 0, 0);
  endtask

  task automatic rand_pix(input int n);
    repeat (n) step(0, 8'($urandom), 1'($urandom_range(0, 1)), 0);
  endtask

  task automatic frame(input int n);
    for (int k = 0; k < n; k++) step(0, 8'($urandom), 1, k == n - 1);
    step(0, 8'($urandom), 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ncyc++;
    rst = 1; hist_valid = 0; in_valid = 0; end_of_frame = 0;
    @(negedge clk);
    ncyc++;
    rst = 0;
    bld_on = 0; pend_m = 0; ready_m = 0; eof_prev_m = 0;
    q.delete();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hist_rd_en", {63'd0, hist_rd_en}, 64'd0);
    chk("rst_hist_addr", {56'd0, hist_addr}, 64'd0);
    chk("rst_lut_ready", {63'd0, lut_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_eof", {63'd0, out_end_of_frame}, 64'd0);
    chk("rst_out_pixel", {56'd0, out_pixel}, 64'd0);
  endtask

  initial begin
    do_reset();
    step(0, 8'h5a, 1, 0);
    rand_pix(20);
    idle(3);
    for (int i = 0; i < 256; i++) hist_mem[i] = 1;
    step(1, 8'($urandom), 1, 0);
    rand_pix(270);
    frame(8);
    step(0, 8'd0, 1, 0); step(0, 8'd127, 1, 0); step(0, 8'd255, 1, 0);
    rand_pix(30);
    idle(3);
    hist_mem[0] = 256;
    for (int i = 1; i < 256; i++) hist_mem[i] = 0;
    step(1, 8'($urandom), 1, 0);
    rand_pix(99);
    frame(5);
    rand_pix(160);
    frame(5);
    rand_pix(30);
    idle(3);
    hist_mem[0] = 1000;
    step(1, 8'd0, 0, 0);
    idle(260);
    frame(3);
    step(0, 8'd0, 1, 0);
    rand_pix(20);
    idle(3);
    hist_mem[0] = 32'hffff_fff0;
    hist_mem[1] = 32'h20;
    for (int i = 2; i < 256; i++) hist_mem[i] = $urandom_range(0, 3);
    step(1, 8'd0, 0, 0);
    idle(260);
    frame(4);
    step(0, 8'd0, 1, 0); step(0, 8'd1, 1, 0); step(0, 8'd2, 1, 0); step(0, 8'd255, 1, 0);
    rand_pix(40);
    idle(3);
    for (int i = 0; i < 256; i++) hist_mem[i] = 2;
    step(1, 8'd0, 0, 0);
    idle(99);
    do_reset();
    idle(300);
    frame(4);
    step(0, 8'h5a, 1, 0);
    rand_pix(20);
    idle(4);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdf_lut_equalizer.md
CDF_LUT_EQUALIZER -- requirements
Module: cdf_lut_equalizer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; there is no other clock domain.
REQ-002 The block SHALL expose parameter PIXELS_LOG2, default 19, the log2 of the normalisation divisor (pixels per frame rounded up to a power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port hist_valid, input, 1 bit: one-cycle pulse meaning a completed histogram is readable.
REQ-006 The block SHALL have port hist_rd_en, output, 1 bit: histogram RAM read enable.
REQ-007 The block SHALL have port hist_addr, output, 8 bits: histogram bin address.
REQ-008 The block SHALL have port hist_data, input, 32 bits: bin count, valid 1 cycle after hist_rd_en.
REQ-009 The block SHALL have port in_pixel, input, 8 bits: input pixel.
REQ-010 The block SHALL have port in_valid, input, 1 bit: input pixel qualifier.
REQ-011 The block SHALL have port end_of_frame, input, 1 bit: frame-end level from the pixel stream.
REQ-012 The block SHALL have port out_pixel, output, 8 bits: remapped pixel.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_pixel qualifier.
REQ-014 The block SHALL have port out_end_of_frame, output, 1 bit: end_of_frame aligned with out_pixel.
REQ-015 The block SHALL have port lut_ready, output, 1 bit: the active LUT holds a computed mapping.
REQ-016 The block SHALL have port busy, output, 1 bit: a LUT build is in progress.

Function
REQ-017 The block SHALL hold two 256x8 LUT banks (active, shadow); builds write only the shadow bank, and pixel lookups read only the active bank.
REQ-018 The FSM SHALL have three states: IDLE, READ and DRAIN.
REQ-019 In IDLE, hist_valid=1 at cycle T SHALL clear the 32-bit accumulator and enter READ at T+1.
REQ-020 In READ, hist_rd_en=1 with hist_addr=0..255 SHALL be driven on cycles T+1..T+256; after addr 255 the FSM goes to DRAIN and then to IDLE.
REQ-021 For each returned hist_data at cycle T+2+i, the block SHALL compute acc += hist_data (accumulation wraps at 32 bits), then write shadow[i] = min(255, (acc_new*255) >> PIXELS_LOG2) using a 40-bit product.
REQ-022 busy SHALL be 1 from T+1 through T+257 inclusive; pending_swap SHALL set at T+258.
REQ-023 hist_valid SHALL be ignored while busy=1.
REQ-024 hist_valid in IDLE with pending_swap=1 SHALL start a new build that overwrites the shadow bank; pending_swap remains set.
REQ-025 A frame boundary SHALL be detected when end_of_frame was 1 on the previous cycle and is 0 on the current cycle.
REQ-026 At a boundary with pending_swap=1 and busy=0, the banks SHALL swap on that edge, lut_ready SHALL be set to 1 and pending_swap SHALL be cleared.
REQ-027 A boundary occurring while busy=1 SHALL NOT swap; the swap is deferred to the next boundary after the build completes.
REQ-028 The pixel path latency SHALL be 2 cycles: in_pixel is registered as the address, then the LUT read is registered; out_valid and out_end_of_frame are delayed by 2 cycles to match.
REQ-029 Pixels sampled on the swap cycle and later SHALL use the new active bank.
REQ-030 While lut_ready=0, out_pixel SHALL equal in_pixel delayed by 2 cycles (identity mapping).
REQ-031 out_pixel is don't-care when out_valid=0, but SHALL never be X after reset.

Reset
REQ-032 rst SHALL set FSM=IDLE, hist_rd_en=0, hist_addr=0, busy=0, lut_ready=0, pending_swap=0, out_valid=0, out_end_of_frame=0, out_pixel=0 and active bank=0.
REQ-033 rst asserted mid-build SHALL abort the build; shadow contents are undefined and no swap occurs afterwards.
REQ-034 LUT RAM contents SHALL NOT be cleared by reset.

Verification
REQ-035 After reset with no build, stream in_pixel=0x5A -> out_pixel=0x5A two cycles later, with lut_ready=0.
REQ-036 With PIXELS_LOG2=8, hist[i]=1 for all bins, hist_valid, then a frame boundary -> lut[0]=0, lut[127]=127, lut[255]=255; verify hist_addr 0..255 on T+1..T+256 and busy deasserting after T+257.
REQ-037 With PIXELS_LOG2=8, hist[0]=256 and all other bins 0 -> every input pixel maps to 255.
REQ-038 With PIXELS_LOG2=8, hist[0]=1000 -> saturation gives lut[0]=255, not wrapped.
REQ-039 Frame boundary while busy=1 -> no swap and lut_ready unchanged; the next boundary after completion swaps the banks.
REQ-040 rst at T+100 of a build -> busy=0 and hist_rd_en=0 the next cycle; a later boundary produces no swap and the identity mapping is retained.
